// File: rtl/ysyx_23060208_dsram_slave.sv
// rtl/ysyx_23060208_dsram_slave.sv - AXI-lite style data SRAM slave with latency-programmable read and write FSMs
// Read and write sides run independently; storage is never cleared by reset.
module ysyx_23060208_dsram_slave #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH_WORDS = 1024,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
   parameter int                    RD_LATENCY  = 2,
   parameter int                    WR_LATENCY  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] dsram_awaddr,
   input  logic                  dsram_awvalid,
   output logic                  dsram_awready,
   input  logic [DATA_WIDTH-1:0] dsram_wdata,
   input  logic [2:0]            dsram_wstrb,
   input  logic                  dsram_wvalid,
   output logic                  dsram_wready,
   output logic [1:0]            dsram_bresp,
   output logic                  dsram_bvalid,
   input  logic                  dsram_bready,
   input  logic [DATA_WIDTH-1:0] dsram_araddr,
   input  logic                  dsram_arvalid,
   output logic                  dsram_arready,
   output logic [DATA_WIDTH-1:0] dsram_rdata,
   output logic [1:0]            dsram_rresp,
   output logic                  dsram_rvalid,
   input  logic                  dsram_rready
);

   localparam int                    IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [DATA_WIDTH-1:0] DEPTH_L = DATA_WIDTH'(DEPTH_WORDS);
   localparam logic [3:0]            RD_LAT  = 4'(RD_LATENCY);
   localparam logic [3:0]            WR_LAT  = 4'(WR_LATENCY);

   typedef enum logic [1:0] {R_IDLE, R_BUSY, R_RESP} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} wstate_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

   function automatic logic f_in_range(input logic [DATA_WIDTH-1:0] a);
      logic [DATA_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ((off >> 2) < DEPTH_L);
   endfunction

   // ---------------- read side ----------------
   rstate_t               r_rstate, w_rstate_nxt;
   logic [3:0]            r_rcnt;
   logic [DATA_WIDTH-1:0] r_araddr;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;
   logic                  w_rd_sample;
   logic [DATA_WIDTH-1:0] w_rd_addr;
   logic [DATA_WIDTH-1:0] w_roff;
   logic [IW-1:0]         w_ridx;
   logic [DATA_WIDTH-1:0] w_rshift;

   // With zero latency the sample happens on the handshake edge, before araddr is latched.
   assign w_rd_addr = (r_rstate == R_IDLE) ? dsram_araddr : r_araddr;
   assign w_roff    = w_rd_addr - BASE_ADDR;
   assign w_ridx    = IW'(w_roff >> 2);
   assign w_rshift  = r_mem[w_ridx] >> {w_rd_addr[1:0], 3'b000};

   always_comb begin
      w_rstate_nxt = r_rstate;
      w_rd_sample  = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            if (dsram_arvalid) begin
               if (RD_LAT == 4'd0) begin
                  w_rstate_nxt = R_RESP;
                  w_rd_sample  = 1'b1;
               end else begin
                  w_rstate_nxt = R_BUSY;
               end
            end
         end
         R_BUSY: begin
            if (r_rcnt == 4'd0) begin
               w_rstate_nxt = R_RESP;
               w_rd_sample  = 1'b1;
            end
         end
         R_RESP: begin
            if (dsram_rready) w_rstate_nxt = R_IDLE;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstate <= R_IDLE;
         r_rcnt   <= 4'd0;
         r_araddr <= '0;
         r_rdata  <= '0;
         r_rresp  <= 2'b00;
      end else begin
         r_rstate <= w_rstate_nxt;
         if (r_rstate == R_IDLE && dsram_arvalid) begin
            r_araddr <= dsram_araddr;
            r_rcnt   <= RD_LAT;
         end else if (r_rstate == R_BUSY && r_rcnt != 4'd0) begin
            r_rcnt <= r_rcnt - 4'd1;
         end
         if (w_rd_sample) begin
            if (f_in_range(w_rd_addr)) begin
               r_rdata <= w_rshift;
               r_rresp <= 2'b00;
            end else begin
               r_rdata <= '0;
               r_rresp <= 2'b11;
            end
         end
      end
   end

   assign dsram_arready = (r_rstate == R_IDLE);
   assign dsram_rvalid  = (r_rstate == R_RESP);
   assign dsram_rdata   = r_rdata;
   assign dsram_rresp   = r_rresp;

   // ---------------- write side ----------------
   wstate_t               r_wstate, w_wstate_nxt;
   logic [3:0]            r_wcnt;
   logic                  r_aw_valid, r_w_valid;
   logic [DATA_WIDTH-1:0] r_awaddr, r_wdata;
   logic [2:0]            r_wstrb;
   logic [1:0]            r_bresp;
   logic                  w_aw_hs, w_w_hs, w_have_both, w_commit;
   logic [DATA_WIDTH-1:0] w_wr_addr, w_wr_data, w_wr_sh, w_woff;
   logic [2:0]            w_wr_strb;
   logic [IW-1:0]         w_widx;
   logic [3:0]            w_be;
   logic [1:0]            w_wr_resp;

   assign w_aw_hs     = dsram_awvalid && dsram_awready;
   assign w_w_hs      = dsram_wvalid && dsram_wready;
   assign w_have_both = (r_aw_valid || w_aw_hs) && (r_w_valid || w_w_hs);
   assign w_wr_addr   = r_aw_valid ? r_awaddr : dsram_awaddr;
   assign w_wr_data   = r_w_valid ? r_wdata : dsram_wdata;
   assign w_wr_strb   = r_w_valid ? r_wstrb : dsram_wstrb;
   assign w_woff      = w_wr_addr - BASE_ADDR;
   assign w_widx      = IW'(w_woff >> 2);
   assign w_wr_sh     = w_wr_data << {w_wr_addr[1:0], 3'b000};

   always_comb begin
      w_be      = 4'b0000;
      w_wr_resp = 2'b00;
      case (w_wr_strb)
         3'b100: w_be = 4'b1111;
         3'b010: w_be = 4'b0011 << w_wr_addr[1:0];
         3'b001: w_be = 4'b0001 << w_wr_addr[1:0];
         default: w_be = 4'b0000;
      endcase
      if ((w_wr_strb != 3'b100 && w_wr_strb != 3'b010 && w_wr_strb != 3'b001) ||
          (w_wr_strb == 3'b100 && w_wr_addr[1:0] != 2'b00) ||
          (w_wr_strb == 3'b010 && w_wr_addr[0]))
         w_wr_resp = 2'b10;
      else if (!f_in_range(w_wr_addr))
         w_wr_resp = 2'b11;
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_commit     = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (w_have_both) begin
               if (WR_LAT == 4'd0) begin
                  w_wstate_nxt = W_RESP;
                  w_commit     = 1'b1;
               end else begin
                  w_wstate_nxt = W_BUSY;
               end
            end
         end
         W_BUSY: begin
            if (r_wcnt == 4'd0) begin
               w_wstate_nxt = W_RESP;
               w_commit     = 1'b1;
            end
         end
         W_RESP: begin
            if (dsram_bready) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wstate   <= W_IDLE;
         r_wcnt     <= 4'd0;
         r_aw_valid <= 1'b0;
         r_w_valid  <= 1'b0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= 3'b000;
         r_bresp    <= 2'b00;
      end else begin
         r_wstate <= w_wstate_nxt;
         if (w_aw_hs) begin
            r_aw_valid <= 1'b1;
            r_awaddr   <= dsram_awaddr;
         end
         if (w_w_hs) begin
            r_w_valid <= 1'b1;
            r_wdata   <= dsram_wdata;
            r_wstrb   <= dsram_wstrb;
         end
         if (r_wstate == W_IDLE && w_have_both)
            r_wcnt <= WR_LAT;
         else if (r_wstate == W_BUSY && r_wcnt != 4'd0)
            r_wcnt <= r_wcnt - 4'd1;
         if (w_commit)
            r_bresp <= w_wr_resp;
         if (r_wstate == W_RESP && dsram_bready) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_bresp    <= 2'b00;
         end
      end
   end

   // Storage has no reset; a commit coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && w_wr_resp == 2'b00) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wr_sh[8*b +: 8];
      end
   end

   assign dsram_awready = (r_wstate == W_IDLE) && !r_aw_valid;
   assign dsram_wready  = (r_wstate == W_IDLE) && !r_w_valid;
   assign dsram_bvalid  = (r_wstate == W_RESP);
   assign dsram_bresp   = r_bresp;

endmodule

// File: tb/tb_ysyx_23060208_dsram_slave.sv
// tb/tb_ysyx_23060208_dsram_slave.sv - directed self-checking bench for the data SRAM slave
module tb_ysyx_23060208_dsram_slave;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [2:0]  wstrb;
   logic [1:0]  bresp, rresp;
   int          vectors = 0;
   int          errors  = 0;

   always #5 clk = ~clk;

   ysyx_23060208_dsram_slave dut (
      .clk(clk), .rst(rst),
      .dsram_awaddr(awaddr), .dsram_awvalid(awvalid), .dsram_awready(awready),
      .dsram_wdata(wdata), .dsram_wstrb(wstrb), .dsram_wvalid(wvalid), .dsram_wready(wready),
      .dsram_bresp(bresp), .dsram_bvalid(bvalid), .dsram_bready(bready),
      .dsram_araddr(araddr), .dsram_arvalid(arvalid), .dsram_arready(arready),
      .dsram_rdata(rdata), .dsram_rresp(rresp), .dsram_rvalid(rvalid), .dsram_rready(rready)
   );

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                           output logic [1:0] resp, output int lat);
      @(posedge clk); #1;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      lat = 0;
      while (!bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
      resp = bresp;
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
      @(posedge clk); #1;
      araddr = a; arvalid = 1; rready = 1;
      @(posedge clk); #1;
      arvalid = 0;
      lat = 0;
      while (!rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
      d = rdata; resp = rresp;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
      awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (awready !== 1'b1) begin errors++; $display("FAIL reset_awready got %b exp 1", awready); end
      vectors++; if (wready !== 1'b1) begin errors++; $display("FAIL reset_wready got %b exp 1", wready); end
      vectors++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready got %b exp 1", arready); end
      vectors++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b exp 0", bvalid); end
      vectors++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
      vectors++; if (bresp !== 2'b00) begin errors++; $display("FAIL reset_bresp got %b exp 00", bresp); end
      vectors++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp got %b exp 00", rresp); end
      vectors++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
      rst = 0;
   endtask

   task automatic test_word_rw;
      logic [1:0] r; logic [31:0] d; int lat;
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 3'b100, r, lat);
      vectors++; if (lat !== 3) begin errors++; $display("FAIL word_wr_latency got %0d exp 3", lat); end
      vectors++; if (r !== 2'b00) begin errors++; $display("FAIL word_bresp got %b exp 00", r); end
      do_read(32'h8000_0010, d, r, lat);
      vectors++; if (lat !== 3) begin errors++; $display("FAIL word_rd_latency got %0d exp 3", lat); end
      vectors++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_rdata got %h exp deadbeef", d); end
      vectors++; if (r !== 2'b00) begin errors++; $display("FAIL word_rresp got %b exp 00", r); end
   endtask

   task automatic test_subword;
      logic [1:0] r; logic [31:0] d; int lat;
      do_write(32'h8000_0010, 32'h1122_3344, 3'b100, r, lat);
      do_write(32'h8000_0013, 32'h0000_00AA, 3'b001, r, lat);
      vectors++; if (r !== 2'b00) begin errors++; $display("FAIL byte_bresp got %b exp 00", r); end
      do_read(32'h8000_0010, d, r, lat);
      vectors++; if (d !== 32'hAA22_3344) begin errors++; $display("FAIL byte_word got %h exp aa223344", d); end
      do_read(32'h8000_0013, d, r, lat);
      vectors++; if (d !== 32'h0000_00AA) begin errors++; $display("FAIL byte_lane got %h exp 000000aa", d); end
      do_write(32'h8000_0012, 32'h0000_5566, 3'b010, r, lat);
      vectors++; if (r !== 2'b00) begin errors++; $display("FAIL half_bresp got %b exp 00", r); end
      do_read(32'h8000_0010, d, r, lat);
      vectors++; if (d !== 32'h5566_3344) begin errors++; $display("FAIL half_word got %h exp 55663344", d); end
      do_read(32'h8000_0012, d, r, lat);
      vectors++; if (d !== 32'h0000_5566) begin errors++; $display("FAIL half_lane got %h exp 00005566", d); end
   endtask

   task automatic test_w_before_aw;
      logic [1:0] r; logic [31:0] d; int lat;
      @(posedge clk); #1;
      wdata = 32'hCAFE_F00D; wstrb = 3'b100; wvalid = 1; bready = 0;
      @(posedge clk); #1;
      wvalid = 0;
      vectors++; if (wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready got %b exp 0", wready); end
      vectors++; if (awready !== 1'b1) begin errors++; $display("FAIL wfirst_awready got %b exp 1", awready); end
      @(posedge clk); #1;
      awaddr = 32'h8000_0020; awvalid = 1;
      @(posedge clk); #1;
      awvalid = 0;
      lat = 0;
      while (!bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
      vectors++; if (lat !== 3) begin errors++; $display("FAIL wfirst_latency got %0d exp 3", lat); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL wfirst_hold%0d got bvalid=%b bresp=%b exp 1/00", i, bvalid, bresp); end
         vectors++; if (awready !== 1'b0 || wready !== 1'b0) begin errors++; $display("FAIL wfirst_ready%0d got aw=%b w=%b exp 0/0", i, awready, wready); end
         @(posedge clk); #1;
      end
      bready = 1;
      @(posedge clk); #1;
      vectors++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin errors++; $display("FAIL wfirst_done got bvalid=%b aw=%b w=%b exp 0/1/1", bvalid, awready, wready); end
      do_read(32'h8000_0020, d, r, lat);
      vectors++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL wfirst_rdata got %h exp cafef00d", d); end
   endtask

   task automatic test_errors;
      logic [1:0] r; logic [31:0] d; int lat;
      do_write(32'h8000_0000, 32'h1234_5678, 3'b100, r, lat);
      do_write(32'h8000_0001, 32'h0000_FFFF, 3'b010, r, lat);
      vectors++; if (r !== 2'b10) begin errors++; $display("FAIL err_half_bresp got %b exp 10", r); end
      do_write(32'h8000_0002, 32'hFFFF_FFFF, 3'b100, r, lat);
      vectors++; if (r !== 2'b10) begin errors++; $display("FAIL err_word_bresp got %b exp 10", r); end
      do_write(32'h8000_0000, 32'hFFFF_FFFF, 3'b011, r, lat);
      vectors++; if (r !== 2'b10) begin errors++; $display("FAIL err_strb_bresp got %b exp 10", r); end
      do_read(32'h8000_0000, d, r, lat);
      vectors++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL err_mem_kept got %h exp 12345678", d); end
      do_read(32'h7FFF_FFFC, d, r, lat);
      vectors++; if (r !== 2'b11 || d !== 32'h0) begin errors++; $display("FAIL err_low_read got rresp=%b rdata=%h exp 11/0", r, d); end
      do_read(32'h8000_1000, d, r, lat);
      vectors++; if (r !== 2'b11 || d !== 32'h0) begin errors++; $display("FAIL err_high_read got rresp=%b rdata=%h exp 11/0", r, d); end
      do_write(32'h8000_1000, 32'h5555_5555, 3'b100, r, lat);
      vectors++; if (r !== 2'b11) begin errors++; $display("FAIL err_high_bresp got %b exp 11", r); end
      do_write(32'h8000_0FFC, 32'hA5A5_5A5A, 3'b100, r, lat);
      vectors++; if (r !== 2'b00) begin errors++; $display("FAIL last_word_bresp got %b exp 00", r); end
      do_read(32'h8000_0FFC, d, r, lat);
      vectors++; if (d !== 32'hA5A5_5A5A || r !== 2'b00) begin errors++; $display("FAIL last_word_read got %h/%b exp a5a55a5a/00", d, r); end
   endtask

   task automatic test_concurrent;
      logic [1:0] r; logic [31:0] d; int lat;
      do_write(32'h8000_0030, 32'h0BAD_F00D, 3'b100, r, lat);
      @(posedge clk); #1;
      awaddr = 32'h8000_0030; wdata = 32'h600D_CAFE; wstrb = 3'b100;
      araddr = 32'h8000_0030;
      awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      lat = 0;
      while (!(rvalid && bvalid) && lat < 20) begin @(posedge clk); #1; lat++; end
      vectors++; if (lat !== 3) begin errors++; $display("FAIL conc_latency got %0d exp 3", lat); end
      vectors++; if (rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL conc_old_data got %h exp 0badf00d", rdata); end
      vectors++; if (bresp !== 2'b00) begin errors++; $display("FAIL conc_bresp got %b exp 00", bresp); end
      @(posedge clk); #1;
      do_read(32'h8000_0030, d, r, lat);
      vectors++; if (d !== 32'h600D_CAFE) begin errors++; $display("FAIL conc_new_data got %h exp 600dcafe", d); end
   endtask

   task automatic test_reset_mid;
      logic [1:0] r; logic [31:0] d; int lat;
      do_write(32'h8000_0040, 32'h1111_1111, 3'b100, r, lat);
      @(posedge clk); #1;
      awaddr = 32'h8000_0040; wdata = 32'h2222_2222; wstrb = 3'b100;
      awvalid = 1; wvalid = 1; bready = 1;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      @(posedge clk); #1;
      rst = 1;
      #1;
      vectors++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_valids got b=%b r=%b exp 0/0", bvalid, rvalid); end
      vectors++; if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin errors++; $display("FAIL rstmid_readies got aw=%b w=%b ar=%b exp 1/1/1", awready, wready, arready); end
      repeat (3) @(posedge clk);
      #1;
      rst = 0;
      do_read(32'h8000_0040, d, r, lat);
      vectors++; if (d !== 32'h1111_1111) begin errors++; $display("FAIL rstmid_mem got %h exp 11111111", d); end
      do_write(32'h8000_0040, 32'h3333_3333, 3'b100, r, lat);
      vectors++; if (r !== 2'b00 || lat !== 3) begin errors++; $display("FAIL rstmid_next_wr got bresp=%b lat=%0d exp 00/3", r, lat); end
      do_read(32'h8000_0040, d, r, lat);
      vectors++; if (d !== 32'h3333_3333) begin errors++; $display("FAIL rstmid_next_rd got %h exp 33333333", d); end
   endtask

   initial begin
      test_reset;
      test_word_rw;
      test_subword;
      test_w_before_aw;
      test_errors;
      test_concurrent;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/ysyx_23060208_dsram_slave.md
YSYX_23060208_DSRAM_SLAVE -- requirements
Module: ysyx_23060208_dsram_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data and address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit storage words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h8000_0000, the byte address of word 0.
REQ-004 SHALL have parameter RD_LATENCY, default 2, the extra cycles between AR handshake and rvalid (0..15 legal).
REQ-005 SHALL have parameter WR_LATENCY, default 2, the extra cycles between write commit-ready and bvalid (0..15 legal).
REQ-006 SHALL have ports clk in 1 (clock); rst in 1 (reset; one clock; asynchronous, active-high).
REQ-007 SHALL have write-address ports: dsram_awaddr in 32; dsram_awvalid in 1; dsram_awready out 1.
REQ-008 SHALL have write-data ports: dsram_wdata in 32; dsram_wstrb in 3 (one-hot: 100 word, 010 half, 001 byte); dsram_wvalid in 1; dsram_wready out 1.
REQ-009 SHALL have write-response ports: dsram_bresp out 2; dsram_bvalid out 1; dsram_bready in 1.
REQ-010 SHALL have read-address ports: dsram_araddr in 32; dsram_arvalid in 1; dsram_arready out 1.
REQ-011 SHALL have read-data ports: dsram_rdata out 32; dsram_rresp out 2; dsram_rvalid out 1; dsram_rready in 1.

Function
REQ-012 SHALL handshake a channel in any cycle where valid and ready are both high at the rising clk edge.
REQ-013 SHALL run the read FSM with states R_IDLE, R_BUSY, R_RESP, independent of the write side.
REQ-014 SHALL drive arready=1 only in R_IDLE.
REQ-015 SHALL, on an AR handshake, latch araddr and move to R_BUSY with a latency counter loaded to RD_LATENCY; with RD_LATENCY=0 it SHALL go directly to R_RESP.
REQ-016 SHALL decrement the counter each cycle in R_BUSY and enter R_RESP when it reaches 0, so rvalid rises exactly RD_LATENCY+1 edges after the AR handshake.
REQ-017 SHALL, on entering R_RESP, sample the addressed word and present rdata = word >> (8*addr[1:0]); the requested byte or half is therefore in rdata[7:0] or [15:0].
REQ-018 SHALL hold rvalid, rdata and rresp stable in R_RESP until rready, then return to R_IDLE; a new AR SHALL NOT be accepted in the same cycle.
REQ-019 SHALL return rresp=2'b00 for in-range addresses and 2'b11 (DECERR) with rdata=0 when araddr < BASE_ADDR or the word index >= DEPTH_WORDS.
REQ-020 SHALL run the write FSM with states W_IDLE, W_BUSY, W_RESP.
REQ-021 SHALL accept AW and W independently in W_IDLE: awready=1 while no address is latched; wready=1 while no data is latched. Both may arrive in either order or in the same cycle.
REQ-022 SHALL, once both AW and W are latched, enter W_BUSY with the counter loaded to WR_LATENCY (W_RESP directly if 0), and commit the write on entry to W_RESP.
REQ-023 SHALL commit by placing wdata's low bytes at byte offset addr[1:0]: word writes all 4 bytes, half writes 2 bytes, byte writes 1 byte; other bytes unchanged.
REQ-024 SHALL return bresp=2'b10 (SLVERR) with no memory change for a misaligned half (addr[0]=1), a misaligned word (addr[1:0]!=0), or a non-one-hot wstrb.
REQ-025 SHALL return bresp=2'b11 with no memory change for out-of-range addresses; otherwise bresp=2'b00.
REQ-026 SHALL hold bvalid and bresp until bready, then clear both latches and return to W_IDLE.
REQ-027 SHALL give read-before-write ordering: if a read sample and a write commit hit the same word in the same cycle, the read returns the pre-write data.

Reset
REQ-028 SHALL, while rst is high, force both FSMs to idle, clear the latches and counters, and drive awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-029 SHALL, when reset is asserted mid-transaction, abandon the transaction with no memory write unless it was committed before reset asserted; memory contents SHALL NOT be cleared.

Verification
REQ-030 Word write then read: AW 0x8000_0010, W 0xDEADBEEF, wstrb 100, bready=1 -> bvalid 3 edges after the last handshake, bresp 00; AR 0x8000_0010 -> rvalid 3 edges later, rdata 0xDEADBEEF, rresp 00.
REQ-031 Byte write: write AW 0x8000_0013, wdata 0x000000AA, wstrb 001 over word 0x11223344 -> read 0x8000_0010 returns 0xAA223344; read 0x8000_0013 returns 0x000000AA.
REQ-032 W arrives 2 cycles before AW, then bready held low 4 cycles -> bvalid and bresp held stable 4 cycles; awready/wready stay 0 until completion.
REQ-033 Errors: half write to 0x8000_0001 -> bresp 10, memory unchanged; read 0x7FFF_FFFC -> rresp 11, rdata 0.
REQ-034 Concurrent read and write to same word, timed so sample and commit coincide -> rdata equals old value; a subsequent read returns the new value.
REQ-035 rst pulsed during W_BUSY -> all valids 0 and readies 1 within the reset; memory unchanged; the next transaction completes normally.
